alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Initiator side of the ALU interface: accepts R-type instruction words plus operand values, queues them, and decodes funct into the 4-bit ALU control code.
- Drives the combinational ALU's control/A/B pins from registers, captures ALUOut/Zero, and returns a tagged result over a valid/ready handshake.
- Sits between the register-read stage and the writeback path of the multi-cycle datapath.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- W, 32, operand/result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request FIFO not full.
- in_instr  in  32  R-type word: [31:26] opcode, [15:11] rd, [5:0] funct.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- alu_ctl  out  4  ALU control code, registered.
- alu_a  out  W  ALU operand A, registered.
- alu_b  out  W  ALU operand B, registered.
- alu_out  in  W  ALU result, combinational from alu_ctl/alu_a/alu_b.
- alu_zero  in  1  ALU zero flag.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  W  captured result.
- res_zero  out  1  captured zero flag.
- res_rd  out  5  destination register tag.
- res_illegal  out  1  request was not a supported op.

Behaviour:
- Reset (async, active-high), all outputs: alu_ctl=15, alu_a=0, alu_b=0, res_valid=0, res_data=0, res_zero=0, res_rd=0, res_illegal=0.
- Reset effects: FIFO emptied, FSM to IDLE. in_ready=1 once rst is low.
- Reset mid-operation discards every queued and in-flight request; no partial result is emitted.
- Push: on in_valid&in_ready. in_ready = !full.
- A push while full is refused even if a pop occurs in the same cycle.
- Pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB compare. Wrap-around is seamless.
- Decode of funct when opcode==0: 32→2 (ADD), 34→6 (SUB), 36→0 (AND), 37→1 (OR), 39→12 (NOR), 42→7 (SLT, unsigned compare).
- Any other funct, or opcode!=0, decodes as illegal: alu_ctl=15.
- FSM IDLE: if FIFO non-empty, pop. Load alu_ctl, alu_a, alu_b, the rd tag and the illegal flag; go to DRIVE.
- FSM DRIVE: ALU pins are stable for exactly one cycle. At the next edge, capture res_data=alu_out and res_zero=alu_zero. Set res_valid=1 and go to RESULT.
- Illegal capture forces res_data=0, res_zero=1, res_illegal=1.
- FSM RESULT: the result is held stable while res_valid&!res_ready.
- On res_valid&res_ready with FIFO non-empty, pop in the same cycle and go to DRIVE; this is the back-to-back path.
- On res_valid&res_ready with FIFO empty, go to IDLE and deassert res_valid.
- Latency: a request accepted at edge E0 into an empty, idle unit drives the ALU after E1 and presents res_valid after E2.
- Sustained throughput is one result per 2 cycles.
- alu_a, alu_b and alu_ctl keep their last values in IDLE/RESULT; they are not cleared.
- Arithmetic is fully inside the ALU. This block does no width extension.
- The FIFO holds DEPTH requests plus one held result, so DEPTH+1 are outstanding at most.

Decomposition:
- Shared package alu_pkg:
  - ALUCtl constants: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, INVALID=15.
  - funct constants: 32, 34, 36, 37, 39, 42.
  - R-type field positions.
  - FSM state enum IDLE/DRIVE/RESULT.
- The same package serves the existing ALU control decoder.
- One sub-module: alu_req_fifo, a synchronous FIFO of {instr, a, b} parameterised by DEPTH, with full/empty outputs.
- Decode and FSM stay in the top level.

Test Plan:
- ADD: instr funct=0x20, rd=3, A=5, B=7, res_ready=1 → alu_ctl=2 for one cycle; res_data=12, res_zero=0, res_rd=3, res_valid 2 cycles after accept.
- SUB zero: funct=0x22, A=9, B=9 → res_data=0, res_zero=1, res_illegal=0.
- SLT unsigned and NOR: A=0xFFFFFFFF, B=1 → res_data=0. NOR of A=0, B=0xFFFF0000 → 0x0000FFFF.
- Illegal: funct=0x08, then opcode=0x23 with funct=0x20 → alu_ctl=15, res_data=0, res_zero=1, res_illegal=1 for both.
- Back-pressure: res_ready=0, push 6 requests → 1st held in RESULT, next 4 queued, in_ready=0 on the 6th.
  - Then set res_ready=1 → all 5 results in order, one every 2 cycles, res_data stable while stalled.
- Reset mid-op: assert rst while in DRIVE with 3 queued → outputs at reset values immediately; no res_valid afterwards; in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, R-type funct values, field positions and issue FSM states.
// Also used by the standalone ALU control decoder.
package alu_pkg;

    localparam logic [3:0] AluCtlAnd     = 4'd0;
    localparam logic [3:0] AluCtlOr      = 4'd1;
    localparam logic [3:0] AluCtlAdd     = 4'd2;
    localparam logic [3:0] AluCtlSub     = 4'd6;
    localparam logic [3:0] AluCtlSlt     = 4'd7;
    localparam logic [3:0] AluCtlNor     = 4'd12;
    localparam logic [3:0] AluCtlInvalid = 4'd15;

    localparam logic [5:0] FunctAdd = 6'd32;
    localparam logic [5:0] FunctSub = 6'd34;
    localparam logic [5:0] FunctAnd = 6'd36;
    localparam logic [5:0] FunctOr  = 6'd37;
    localparam logic [5:0] FunctNor = 6'd39;
    localparam logic [5:0] FunctSlt = 6'd42;

    localparam int unsigned OpcodeMsb = 31;
    localparam int unsigned OpcodeLsb = 26;
    localparam int unsigned RdMsb     = 15;
    localparam int unsigned RdLsb     = 11;
    localparam int unsigned FunctMsb  = 5;
    localparam int unsigned FunctLsb  = 0;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StResult
    } issue_state_e;

    function automatic logic [3:0] decode_alu_ctl(input logic [31:0] instr);
        logic [3:0] ctl;
        ctl = AluCtlInvalid;
        if (instr[OpcodeMsb:OpcodeLsb] == 6'd0) begin
            case (instr[FunctMsb:FunctLsb])
                FunctAdd: ctl = AluCtlAdd;
                FunctSub: ctl = AluCtlSub;
                FunctAnd: ctl = AluCtlAnd;
                FunctOr:  ctl = AluCtlOr;
                FunctNor: ctl = AluCtlNor;
                FunctSlt: ctl = AluCtlSlt;
                default:  ctl = AluCtlInvalid;
            endcase
        end
        return ctl;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request queue for the ALU issue unit. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate count.
module alu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 96
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Queues R-type requests, drives a combinational ALU from registers for one cycle, and returns
// the captured, rd-tagged result over a valid/ready handshake.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_instr,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [3:0]   alu_ctl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zero,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_zero,
    output logic [4:0]   res_rd,
    output logic         res_illegal
);

    localparam int unsigned DW = 32 + 2 * W;

    issue_state_e r_state;
    issue_state_e w_state_next;

    logic [DW-1:0] w_fifo_rdata;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_capture;
    logic          w_release;
    logic [31:0]   w_instr;
    logic [3:0]    w_ctl;

    logic [3:0]    r_alu_ctl;
    logic [W-1:0]  r_alu_a;
    logic [W-1:0]  r_alu_b;
    logic [4:0]    r_drv_rd;
    logic          r_drv_illegal;
    logic          r_res_valid;
    logic [W-1:0]  r_res_data;
    logic          r_res_zero;
    logic [4:0]    r_res_rd;
    logic          r_res_illegal;

    alu_req_fifo #(
        .DEPTH(DEPTH),
        .DW   (DW)
    ) u_req_fifo (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_push (in_valid),
        .i_wdata({in_instr, in_a, in_b}),
        .i_pop  (w_pop),
        .o_rdata(w_fifo_rdata),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    assign in_ready = !w_full;
    assign w_instr  = w_fifo_rdata[DW-1:2*W];
    assign w_ctl    = decode_alu_ctl(w_instr);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StDrive;
                end
            end
            StDrive: begin
                w_capture    = 1'b1;
                w_state_next = StResult;
            end
            StResult: begin
                // Back-to-back: hand off the held result and start the next request together.
                if (res_ready) begin
                    w_release = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = StDrive;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_alu_ctl     <= AluCtlInvalid;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_drv_rd      <= '0;
            r_drv_illegal <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_zero    <= 1'b0;
            r_res_rd      <= '0;
            r_res_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_alu_ctl     <= w_ctl;
                r_alu_a       <= w_fifo_rdata[2*W-1:W];
                r_alu_b       <= w_fifo_rdata[W-1:0];
                r_drv_rd      <= w_instr[RdMsb:RdLsb];
                r_drv_illegal <= (w_ctl == AluCtlInvalid);
            end
            if (w_capture) begin
                r_res_valid   <= 1'b1;
                r_res_data    <= r_drv_illegal ? '0 : alu_out;
                r_res_zero    <= r_drv_illegal ? 1'b1 : alu_zero;
                r_res_rd      <= r_drv_rd;
                r_res_illegal <= r_drv_illegal;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign alu_ctl     = r_alu_ctl;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_zero    = r_res_zero;
    assign res_rd      = r_res_rd;
    assign res_illegal = r_res_illegal;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU and a result scoreboard.
module tb_alu_issue_unit;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        zero;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_instr;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   alu_ctl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_out;
    logic         alu_zero;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_zero;
    logic [4:0]   res_rd;
    logic         res_illegal;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t q[$];

    alu_issue_unit #(
        .DEPTH(DEPTH),
        .W    (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_ctl    (alu_ctl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_rd     (res_rd),
        .res_illegal(res_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU on the other side of the interface.
    always_comb begin
        alu_out = '0;
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = {31'b0, alu_a < alu_b};
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = '0;
        endcase
    end
    assign alu_zero = (alu_out == '0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [5:0] funct);
        return {op, 10'd0, rd, 5'd0, funct};
    endfunction

    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        e.rd   = instr[15:11];
        e.ill  = 1'b0;
        e.data = '0;
        if (instr[31:26] != 6'd0) e.ill = 1'b1;
        else begin
            case (instr[5:0])
                6'd32:   e.data = a + b;
                6'd34:   e.data = a - b;
                6'd36:   e.data = a & b;
                6'd37:   e.data = a | b;
                6'd39:   e.data = ~(a | b);
                6'd42:   e.data = (a < b) ? 32'd1 : 32'd0;
                default: e.ill = 1'b1;
            endcase
        end
        if (e.ill) begin
            e.data = '0;
            e.zero = 1'b1;
        end else begin
            e.zero = (e.data == '0);
        end
        return e;
    endfunction

    // Scoreboard: every cycle a result is valid it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            chk1("result_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                chk("res_data", res_data, q[0].data);
                chk1("res_zero", res_zero, q[0].zero);
                chk("res_rd", 32'(res_rd), 32'(q[0].rd));
                chk1("res_illegal", res_illegal, q[0].ill);
                if (res_ready) void'(q.pop_front());
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_a     = a;
        in_b     = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk1("push_accepted", acc, 1'b1);
        if (acc) q.push_back(model(instr, a, b));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || res_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk1("drained", (q.size() == 0) && !res_valid, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_alu_ctl"}, 32'(alu_ctl), 32'd15);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_alu_b"}, alu_b, 32'd0);
        chk1({tag, "_res_valid"}, res_valid, 1'b0);
        chk({tag, "_res_data"}, res_data, 32'd0);
        chk1({tag, "_res_zero"}, res_zero, 1'b0);
        chk({tag, "_res_rd"}, 32'(res_rd), 32'd0);
        chk1({tag, "_res_illegal"}, res_illegal, 1'b0);
    endtask

    initial begin
        int last;
        int seen;
        bit got;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("in_ready_after_reset", in_ready, 1'b1);

        // ADD with latency profile.
        push(mk(6'd0, 5'd3, 6'h20), 32'd5, 32'd7);
        chk1("add_valid_e0", res_valid, 1'b0);
        chk("add_ctl_e0", 32'(alu_ctl), 32'd15);
        @(posedge clk);
        #1;
        chk("add_ctl_e1", 32'(alu_ctl), 32'd2);
        chk("add_a_e1", alu_a, 32'd5);
        chk("add_b_e1", alu_b, 32'd7);
        chk1("add_valid_e1", res_valid, 1'b0);
        @(posedge clk);
        #1;
        chk1("add_valid_e2", res_valid, 1'b1);
        drain();

        // Illegal funct.
        push(mk(6'd0, 5'd4, 6'h08), 32'd1, 32'd2);
        @(posedge clk);
        #1;
        chk("illegal_funct_ctl", 32'(alu_ctl), 32'd15);
        drain();

        push(mk(6'd0, 5'd5, 6'h22), 32'd9, 32'd9);
        push(mk(6'd0, 5'd6, 6'h2a), 32'hFFFF_FFFF, 32'd1);
        push(mk(6'd0, 5'd7, 6'h27), 32'd0, 32'hFFFF_0000);
        drain();

        // Illegal opcode with a legal-looking funct.
        push(mk(6'h23, 5'd8, 6'h20), 32'd3, 32'd4);
        @(posedge clk);
        #1;
        chk("illegal_opcode_ctl", 32'(alu_ctl), 32'd15);
        drain();

        // Back-pressure: one result held, DEPTH queued, next push refused.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk(6'd0, 5'(i + 10), 6'h20), 32'(i), 32'd100);
        in_valid = 1'b1;
        in_instr = mk(6'd0, 5'd20, 6'h20);
        in_a     = 32'd1;
        in_b     = 32'd1;
        repeat (3) begin
            @(negedge clk);
            chk1("full_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        last      = 0;
        for (int i = 0; i < 5; i++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (res_valid) got = 1'b1;
            end
            chk1("bp_result_seen", got, 1'b1);
            if (i > 0) chk("bp_gap", 32'(cyc - last), 32'd2);
            last = cyc;
            @(posedge clk);
            #1;
        end
        drain();

        // Reset while DRIVE with three requests queued.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mk(6'd0, 5'(i + 1), 6'h25), 32'h100 + 32'(i), 32'd0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_drive_a", alu_a, 32'h101);
        chk1("mid_drive_valid", res_valid, 1'b0);
        rst = 1'b1;
        q.delete();
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("in_ready_after_mid_reset", in_ready, 1'b1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("no_result_after_reset", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        push(mk(6'd0, 5'd31, 6'h24), 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
